// File: rtl/charger_pkg.sv
// -----------------------------------------------------------------------------
// charger_pkg
// Shared definitions for the coin-operated phone charger.
//   state_t   : 3-bit state code, also decoded by the state-lamp display
//   COIN*_VAL : yuan value of each coin input
//   coin_sum  : yuan added by a same-cycle combination of coin pulses
// -----------------------------------------------------------------------------
package charger_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_WAIT   = 3'd1,
    ST_INSERT = 3'd2,
    ST_CHARGE = 3'd3,
    ST_REFUND = 3'd4
  } state_t;

  localparam logic [7:0] COIN1_VAL = 8'd1;
  localparam logic [7:0] COIN5_VAL = 8'd5;

  // coin1 and coin5 in the same cycle count as a single 6-yuan addition.
  function automatic logic [7:0] coin_sum(input logic c1, input logic c5);
    logic [7:0] s;
    s = 8'd0;
    if (c1) s = s + COIN1_VAL;
    if (c5) s = s + COIN5_VAL;
    return s;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// -----------------------------------------------------------------------------
// sec_tick_gen
// One-second tick prescaler. Counts 0..CLK_HZ-1; tick is high during the
// last count of each second. clr restarts the count so the next tick comes a
// full second later.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   clr   : synchronous restart of the count
//   tick  : one-cycle pulse per second
// -----------------------------------------------------------------------------
module sec_tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == CNT_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/charger_controller.sv
// -----------------------------------------------------------------------------
// charger_controller
// Master sequencer of the coin-operated phone charger: power on/off, credit
// accumulation, charging countdown and refund hold.
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   power_btn       : pulse, toggles power
//   coin1, coin5    : pulses, coin inserted
//   confirm, cancel : pulses, start charging / abort with refund
//   state           : current state code (charger_pkg::state_t)
//   credit          : credit in yuan
//   remain_time     : charging seconds remaining
//   refund_amt      : yuan to return, valid in REFUND
//   refund_pulse    : one cycle on REFUND entry
//   coin_reject     : one cycle when a coin is refused
//   charging        : relay enable, high only in CHARGE
// Build option: CHARGE_CANCEL_REFUND_EN makes cancel during CHARGE refund the
// unused whole yuan; without it cancel is ignored during CHARGE.
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module charger_controller
  import charger_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SEC_PER_YUAN = 10,
  parameter int MAX_CREDIT   = 20,
  parameter int IDLE_TIMEOUT = 10,
  parameter int REFUND_HOLD  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        power_btn,
  input  logic        coin1,
  input  logic        coin5,
  input  logic        confirm,
  input  logic        cancel,
  output logic [2:0]  state,
  output logic [7:0]  credit,
  output logic [15:0] remain_time,
  output logic [7:0]  refund_amt,
  output logic        refund_pulse,
  output logic        coin_reject,
  output logic        charging
);

  localparam logic [8:0]  CREDIT_CAP = 9'(MAX_CREDIT);
  localparam logic [15:0] SPY        = 16'(SEC_PER_YUAN);
  localparam logic [15:0] IDLE_LAST  = 16'(IDLE_TIMEOUT - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(REFUND_HOLD - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_credit, w_credit_nxt;
  logic [15:0] r_remain, w_remain_nxt;
  logic [7:0]  r_refund, w_refund_nxt;
  logic        r_refund_pulse, w_refund_pulse_nxt;
  logic        r_coin_reject, w_coin_reject_nxt;
  logic        r_charging, w_charging_nxt;
  // Seconds spent in the current state; serves as the WAIT idle timer and
  // the REFUND hold timer (never both at once).
  logic [15:0] r_sec_cnt, w_sec_cnt_nxt;

  logic        w_tick;
  logic        w_clr;
  logic        w_coin;
  logic [7:0]  w_add;
  logic        w_fits;

  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_OFF;
      r_credit       <= 8'd0;
      r_remain       <= 16'd0;
      r_refund       <= 8'd0;
      r_refund_pulse <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_charging     <= 1'b0;
      r_sec_cnt      <= 16'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_credit       <= w_credit_nxt;
      r_remain       <= w_remain_nxt;
      r_refund       <= w_refund_nxt;
      r_refund_pulse <= w_refund_pulse_nxt;
      r_coin_reject  <= w_coin_reject_nxt;
      r_charging     <= w_charging_nxt;
      r_sec_cnt      <= w_sec_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_credit_nxt       = r_credit;
    w_remain_nxt       = r_remain;
    w_refund_nxt       = r_refund;
    w_refund_pulse_nxt = 1'b0;
    w_coin_reject_nxt  = 1'b0;
    w_sec_cnt_nxt      = r_sec_cnt + 16'(w_tick);
    w_coin             = coin1 | coin5;
    w_add              = coin_sum(coin1, coin5);
    w_fits             = ({1'b0, r_credit} + {1'b0, w_add}) <= CREDIT_CAP;

    case (r_state)
      ST_OFF: begin
        if (power_btn) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_coin) begin
          if (w_fits) begin
            w_credit_nxt = r_credit + w_add;
            w_state_nxt  = ST_INSERT;
          end else begin
            w_coin_reject_nxt = 1'b1;
          end
        end else if (w_tick && (r_sec_cnt == IDLE_LAST)) begin
          w_state_nxt = ST_OFF;
        end
      end
      ST_INSERT: begin
        if (cancel) begin
          w_refund_nxt       = r_credit;
          w_credit_nxt       = 8'd0;
          w_refund_pulse_nxt = 1'b1;
          w_state_nxt        = ST_REFUND;
        end else if (confirm) begin
          w_remain_nxt = 16'(r_credit) * SPY;
          w_credit_nxt = 8'd0;
          w_state_nxt  = ST_CHARGE;
        end else if (w_coin) begin
          if (w_fits) w_credit_nxt = r_credit + w_add;
          else        w_coin_reject_nxt = 1'b1;
        end
      end
      ST_CHARGE: begin
`ifdef CHARGE_CANCEL_REFUND_EN
        if (cancel) begin
          w_refund_nxt       = 8'(r_remain / SPY);
          w_remain_nxt       = 16'd0;
          w_refund_pulse_nxt = 1'b1;
          w_state_nxt        = ST_REFUND;
        end else begin
          w_coin_reject_nxt = w_coin;
          if (w_tick) begin
            if (r_remain <= 16'd1) begin
              w_remain_nxt = 16'd0;
              w_state_nxt  = ST_WAIT;
            end else begin
              w_remain_nxt = r_remain - 16'd1;
            end
          end
        end
`else
        w_coin_reject_nxt = w_coin;
        if (w_tick) begin
          if (r_remain <= 16'd1) begin
            w_remain_nxt = 16'd0;
            w_state_nxt  = ST_WAIT;
          end else begin
            w_remain_nxt = r_remain - 16'd1;
          end
        end
`endif
      end
      ST_REFUND: begin
        w_coin_reject_nxt = w_coin;
        if (w_tick && (r_sec_cnt == HOLD_LAST)) begin
          w_refund_nxt = 8'd0;
          w_state_nxt  = ST_WAIT;
        end
      end
      default: begin
        // Unused codes recover to OFF with everything cleared.
        w_state_nxt  = ST_OFF;
        w_credit_nxt = 8'd0;
        w_remain_nxt = 16'd0;
        w_refund_nxt = 8'd0;
      end
    endcase

    // Power-off outranks every other event and forfeits any credit.
    if (power_btn && (r_state != ST_OFF)) begin
      w_state_nxt        = ST_OFF;
      w_credit_nxt       = 8'd0;
      w_remain_nxt       = 16'd0;
      w_refund_nxt       = 8'd0;
      w_refund_pulse_nxt = 1'b0;
      w_coin_reject_nxt  = 1'b0;
    end

    w_charging_nxt = (w_state_nxt == ST_CHARGE);

    // Every state entry restarts the second prescaler and the state timer.
    w_clr = (w_state_nxt != r_state);
    if (w_clr) w_sec_cnt_nxt = 16'd0;
  end

  assign state        = r_state;
  assign credit       = r_credit;
  assign remain_time  = r_remain;
  assign refund_amt   = r_refund;
  assign refund_pulse = r_refund_pulse;
  assign coin_reject  = r_coin_reject;
  assign charging     = r_charging;

endmodule
